clk_divider_multi: RTL and testbench

- Multi-channel, runtime-programmable clock divider generating NUM_CH independent divided clocks from clk_in.
- Each channel supports:
  - a programmable divisor;
  - glitch-free enable/disable;
  - divisor updates deferred to a period boundary;
  - a one-cycle tick strobe at each period start.
- A shared sync input phase-aligns all running channels.
- Used as the system clock/strobe generator feeding CPU, peripherals and debug-stepping logic.

---
 rtl/clk_divider_multi.sv | 97 +++++++++
 tb/tb_clk_divider_multi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider with glitch-free enable, deferred
// divisor updates, per-period tick strobes and a shared phase-align sync.
module clk_divider_multi #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_we,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_pend
);

  localparam int                RST_EFF = (RESET_DIV < 2) ? 2 : RESET_DIV;
  localparam logic [DIV_W-1:0]  RST_DIV = DIV_W'(RST_EFF);
  localparam logic [DIV_W-1:0]  ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0]  TWO     = DIV_W'(2);

  // Divisors 0 and 1 are stored verbatim but run as 2.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic             run;
    logic             clk_q;
    logic             tick_q;
    logic             pend_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] din;
    logic [DIV_W-1:0] neff;
    logic [DIV_W-1:0] half;
    logic             last;
    logic             start;

    assign din   = div_in[k*DIV_W +: DIV_W];
    assign neff  = eff_div(div_act);
    assign half  = neff >> 1;
    assign last  = (cnt == neff - ONE);
    // sync only restarts channels that are enabled; an idle enabled channel starts anyway
    assign start = en[k] && (!run || sync || last);

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        run     <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        pend_q  <= 1'b0;
        cnt     <= '0;
        div_act <= RST_DIV;
        div_nxt <= RST_DIV;
      end else if (start) begin
        run    <= 1'b1;
        clk_q  <= 1'b1;
        tick_q <= 1'b1;
        cnt    <= '0;
        if (div_we[k]) begin
          div_act <= din;
          pend_q  <= 1'b0;
        end else if (pend_q) begin
          div_act <= div_nxt;
          pend_q  <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
        if (div_we[k]) begin
          div_nxt <= din;
          pend_q  <= 1'b1;
        end
        if (!run) begin
          clk_q <= 1'b0;
          cnt   <= '0;
        end else if (last) begin
          // period finished with en low: park with the output low
          run   <= 1'b0;
          clk_q <= 1'b0;
          cnt   <= '0;
        end else begin
          if (cnt == half - ONE) clk_q <= 1'b0;
          cnt <= cnt + ONE;
        end
      end
    end

    assign clk_out[k]  = clk_q;
    assign tick[k]     = tick_q;
    assign div_pend[k] = pend_q;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Randomized and directed bench for clk_divider_multi against a period-position
// reference model that derives clk_out/tick from where each channel sits in its period.
module tb_clk_divider_multi;
  localparam int NUM_CH    = 2;
  localparam int DIV_W     = 16;
  localparam int RESET_DIV = 2;

  logic                    clk_in = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en;
  logic                    sync;
  logic [NUM_CH*DIV_W-1:0] div_in;
  logic [NUM_CH-1:0]       div_we;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       div_pend;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: position inside the current period, plus divisor bookkeeping.
  int m_run  [NUM_CH];
  int m_pos  [NUM_CH];
  int m_n    [NUM_CH];
  int m_p    [NUM_CH];
  int m_pend [NUM_CH];

  clk_divider_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .div_in   (div_in),
    .div_we   (div_we),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_pend[c] = 0;
      m_n[c] = (RESET_DIV < 2) ? 2 : RESET_DIV;
      m_p[c] = m_n[c];
    end
  endtask

  function automatic logic m_starts(input int c, input logic e, input logic s);
    return e && (!m_run[c] || s || m_pos[c] == eff(m_n[c]) - 1);
  endfunction

  task automatic m_step();
    for (int c = 0; c < NUM_CH; c++) begin
      int d;
      d = int'(div_in[c*DIV_W +: DIV_W]);
      if (m_starts(c, en[c], sync)) begin
        m_run[c] = 1; m_pos[c] = 0;
        if (div_we[c]) begin m_n[c] = d; m_pend[c] = 0; end
        else if (m_pend[c] != 0) begin m_n[c] = m_p[c]; m_pend[c] = 0; end
      end else begin
        if (div_we[c]) begin m_p[c] = d; m_pend[c] = 1; end
        if (m_run[c] != 0) begin
          if (m_pos[c] == eff(m_n[c]) - 1) begin m_run[c] = 0; m_pos[c] = 0; end
          else m_pos[c]++;
        end
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_clk();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_run[c] != 0) && (m_pos[c] < eff(m_n[c]) / 2);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_tick();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_run[c] != 0) && (m_pos[c] == 0);
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_pendv();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_pend[c] != 0);
    return v;
  endfunction

  // One clk_in cycle: drive inputs, let the edge happen, advance model, compare.
  task automatic step(input logic [1:0] e, input logic s, input logic [1:0] we,
                      input logic [15:0] d0, input logic [15:0] d1);
    en = e; sync = s; div_we = we; div_in = {d1, d0};
    @(posedge clk_in);
    m_step();
    #1;
    chk("clk_out", 32'(clk_out), 32'(m_clk()));
    chk("tick", 32'(tick), 32'(m_tick()));
    chk("div_pend", 32'(div_pend), 32'(m_pendv()));
  endtask

  task automatic idle_n(input logic [1:0] e, input int n);
    for (int i = 0; i < n; i++) step(e, 1'b0, 2'b00, 16'd0, 16'd0);
  endtask

  initial begin
    en = '0; sync = 1'b0; div_in = '0; div_we = '0;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_pend", 32'(div_pend), 32'd0);
    @(posedge clk_in); @(posedge clk_in);
    #1 rst_n = 1'b1;

    // Reset divisor of 2: first edge high, then toggling every cycle.
    step(2'b01, 1'b0, 2'b00, 16'd0, 16'd0);
    chk("first_edge_high", 32'(clk_out[0]), 32'd1);
    idle_n(2'b01, 5);

    // Write 5 mid-period: pending until the boundary, then 2 high / 3 low.
    while (m_starts(0, 1'b1, 1'b0)) step(2'b01, 1'b0, 2'b00, 16'd0, 16'd0);
    step(2'b01, 1'b0, 2'b01, 16'd5, 16'd0);
    chk("pend_after_write", 32'(div_pend[0]), 32'd1);
    idle_n(2'b01, 12);

    // Divisor 8, drop enable at c=2: period completes, then stays low.
    while (m_starts(0, 1'b1, 1'b0)) step(2'b01, 1'b0, 2'b00, 16'd0, 16'd0);
    step(2'b01, 1'b0, 2'b01, 16'd8, 16'd0);
    while (!m_starts(0, 1'b1, 1'b0)) step(2'b01, 1'b0, 2'b00, 16'd0, 16'd0);
    idle_n(2'b01, 3);
    idle_n(2'b00, 14);
    chk("parked_low", 32'(clk_out[0]), 32'd0);
    step(2'b01, 1'b0, 2'b00, 16'd0, 16'd0);
    chk("reenable_high", 32'(clk_out[0]), 32'd1);

    // ch0 N=4, ch1 N=6 with random phase offset, then sync aligns them.
    idle_n(2'b00, 10);
    step(2'b01, 1'b0, 2'b11, 16'd4, 16'd6);
    idle_n(2'b01, $urandom_range(1, 5));
    step(2'b11, 1'b0, 2'b00, 16'd0, 16'd0);
    idle_n(2'b11, $urandom_range(1, 7));
    step(2'b11, 1'b1, 2'b00, 16'd0, 16'd0);
    chk("sync_clk", 32'(clk_out), 32'd3);
    chk("sync_tick", 32'(tick), 32'd3);
    idle_n(2'b11, 14);

    // Divisors 0 and 1 behave as 2.
    step(2'b11, 1'b0, 2'b11, 16'd0, 16'd1);
    idle_n(2'b11, 12);
    // Write coincident with a period start takes effect immediately.
    while (!m_starts(0, 1'b1, 1'b0)) step(2'b11, 1'b0, 2'b00, 16'd0, 16'd0);
    step(2'b11, 1'b0, 2'b01, 16'd3, 16'd0);
    chk("coinc_no_pend", 32'(div_pend[0]), 32'd0);
    idle_n(2'b11, 9);

    // Divisor write on an idle disabled channel.
    idle_n(2'b00, 12);
    step(2'b00, 1'b0, 2'b10, 16'd0, 16'd7);
    idle_n(2'b00, 3);
    idle_n(2'b10, 10);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] e, we;
      logic s;
      e  = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom);
      s  = ($urandom_range(0, 15) == 0);
      we = 2'(($urandom_range(0, 7) == 0) ? 1 : 0) | 2'(($urandom_range(0, 7) == 0) ? 2 : 0);
      step(e, s, we, 16'($urandom_range(0, 9)), 16'($urandom_range(0, 9)));
    end

    // Async reset mid-high phase at N=10.
    idle_n(2'b00, 12);
    step(2'b01, 1'b0, 2'b01, 16'd10, 16'd0);
    idle_n(2'b01, 2);
    step(2'b01, 1'b0, 2'b10, 16'd0, 16'd9);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("async_clk", 32'(clk_out), 32'd0);
    chk("async_tick", 32'(tick), 32'd0);
    chk("async_pend", 32'(div_pend), 32'd0);
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    idle_n(2'b01, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
